// File: rtl/rename_map_if.sv
// Bundle of rename, commit and flush signals between decode/commit logic and the rename map.
// The master side drives rename groups and commit/flush events; the slave side is the map.
interface rename_map_if #(
    parameter int NDEC     = 4,
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = 5,
    parameter int RA       = 6
);
    logic [NDEC-1:0]     rn_valid;
    logic [LNCOMMIT-1:0] rn_base;
    logic [5*NDEC-1:0]   rn_rs1;
    logic [5*NDEC-1:0]   rn_rs2;
    logic [5*NDEC-1:0]   rn_rs3;
    logic [5*NDEC-1:0]   rn_rd;
    logic [NDEC-1:0]     rn_makes_rd;
    logic                rn_stall;
    logic [RA*NDEC-1:0]  rn_rs1_out;
    logic [RA*NDEC-1:0]  rn_rs2_out;
    logic [RA*NDEC-1:0]  rn_rs3_out;
    logic [LNCOMMIT-1:0] commit_head;
    logic [NCOMMIT-1:0]  commit_done;
    logic                flush;
    logic [LNCOMMIT-1:0] flush_addr;
    logic                map_busy;

    modport master (
        output rn_valid, rn_base, rn_rs1, rn_rs2, rn_rs3, rn_rd, rn_makes_rd, rn_stall,
        output commit_head, commit_done, flush, flush_addr,
        input  rn_rs1_out, rn_rs2_out, rn_rs3_out, map_busy
    );

    modport slave (
        input  rn_valid, rn_base, rn_rs1, rn_rs2, rn_rs3, rn_rd, rn_makes_rd, rn_stall,
        input  commit_head, commit_done, flush, flush_addr,
        output rn_rs1_out, rn_rs2_out, rn_rs3_out, map_busy
    );
endinterface

// File: rtl/rename_map.sv
// Rename map: architectural register -> newest in-flight commit station, with intra-group
// bypass on lookup and a multi-clock rebuild from the surviving commit window after a flush.
module rename_map #(
    parameter int NDEC     = 4,
    parameter int NARCH    = 32,
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = 5,
    parameter int RA       = 6
) (
    input  logic         clk,
    input  logic         reset,
    rename_map_if.slave  bus
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_REBUILD = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic [LNCOMMIT-1:0]             ptr_q, ptr_d;
    logic [LNCOMMIT-1:0]             end_q, end_d;
    logic [NARCH-1:0]                map_vld_q, map_vld_d;
    logic [NARCH-1:0][LNCOMMIT-1:0]  map_tag_q, map_tag_d;
    logic [NCOMMIT-1:0][4:0]         win_rd_q, win_rd_d;
    logic [NCOMMIT-1:0]              win_mk_q, win_mk_d;

    logic                            busy_s;
    logic                            accept_s;
    logic [LNCOMMIT-1:0]             rem_s;
    logic [LNCOMMIT:0]               rb_cnt_s;
    logic [LNCOMMIT-1:0]             ptr_adv_s;
    logic [NDEC-1:0][LNCOMMIT-1:0]   rn_st_s;
    logic [NDEC-1:0][LNCOMMIT-1:0]   rb_st_s;
    logic [RA*NDEC-1:0]              rs1_out_s, rs2_out_s, rs3_out_s;

    // Resolve one source: x0, then the youngest older slot in the group, then the live map entry.
    function automatic logic [RA-1:0] lookup_tag(
        input logic [4:0]                      s,
        input int                              slot,
        input logic [NDEC-1:0]                 valid,
        input logic [NDEC-1:0]                 mk,
        input logic [5*NDEC-1:0]               rd,
        input logic [LNCOMMIT-1:0]             base,
        input logic [NARCH-1:0]                vld,
        input logic [NARCH-1:0][LNCOMMIT-1:0]  tag,
        input logic [NCOMMIT-1:0]              done
    );
        logic [RA-1:0] res;
        logic          hit;
        res = RA'(s);
        hit = 1'b0;
        if (s == 5'd0) begin
            res = '0;
        end else begin
            for (int k = 0; k < NDEC; k++) begin
                if ((k < slot) && valid[k] && mk[k] && (rd[5*k +: 5] == s)) begin
                    hit = 1'b1;
                    res = {1'b1, base + LNCOMMIT'(k)};
                end else begin
                    hit = hit;
                end
            end
            if (hit) begin
                res = res;
            end else if ((int'(s) < NARCH) && vld[s] && !done[tag[s]]) begin
                res = {1'b1, tag[s]};
            end else begin
                res = RA'(s);
            end
        end
        return res;
    endfunction

    assign busy_s       = (state_q == S_REBUILD) | bus.flush;
    assign accept_s     = !busy_s && !bus.rn_stall;
    assign bus.map_busy = busy_s;
    assign bus.rn_rs1_out = rs1_out_s;
    assign bus.rn_rs2_out = rs2_out_s;
    assign bus.rn_rs3_out = rs3_out_s;

    // Station numbers for the incoming group and for the current rebuild slice.
    always_comb begin
        rn_st_s = '0;
        rb_st_s = '0;
        for (int j = 0; j < NDEC; j++) begin
            rn_st_s[j] = bus.rn_base + LNCOMMIT'(j);
            rb_st_s[j] = ptr_q + LNCOMMIT'(j);
        end
        rem_s     = end_q - ptr_q;
        rb_cnt_s  = (int'(rem_s) < NDEC) ? {1'b0, rem_s} : (LNCOMMIT+1)'(NDEC);
        ptr_adv_s = ptr_q + rb_cnt_s[LNCOMMIT-1:0];
    end

    // Combinational source-tag lookup for every slot.
    always_comb begin
        rs1_out_s = '0;
        rs2_out_s = '0;
        rs3_out_s = '0;
        for (int j = 0; j < NDEC; j++) begin
            rs1_out_s[j*RA +: RA] = lookup_tag(bus.rn_rs1[5*j +: 5], j, bus.rn_valid,
                bus.rn_makes_rd, bus.rn_rd, bus.rn_base, map_vld_q, map_tag_q, bus.commit_done);
            rs2_out_s[j*RA +: RA] = lookup_tag(bus.rn_rs2[5*j +: 5], j, bus.rn_valid,
                bus.rn_makes_rd, bus.rn_rd, bus.rn_base, map_vld_q, map_tag_q, bus.commit_done);
            rs3_out_s[j*RA +: RA] = lookup_tag(bus.rn_rs3[5*j +: 5], j, bus.rn_valid,
                bus.rn_makes_rd, bus.rn_rd, bus.rn_base, map_vld_q, map_tag_q, bus.commit_done);
        end
    end

    // Rebuild sequencing; a flush always restarts the walk from commit_head.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        end_d   = end_q;
        if (bus.flush) begin
            ptr_d   = bus.commit_head;
            end_d   = bus.flush_addr;
            state_d = (bus.commit_head == bus.flush_addr) ? S_IDLE : S_REBUILD;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_REBUILD: begin
                    ptr_d   = ptr_adv_s;
                    state_d = (ptr_adv_s == end_q) ? S_IDLE : S_REBUILD;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Map update: retire committed entries, then flush clear, rename writes or rebuild writes.
    always_comb begin
        map_vld_d = map_vld_q;
        map_tag_d = map_tag_q;
        for (int e = 0; e < NARCH; e++) begin
            if (map_vld_q[e] && bus.commit_done[map_tag_q[e]]) begin
                map_vld_d[e] = 1'b0;
            end else begin
                map_vld_d[e] = map_vld_q[e];
            end
        end
        if (bus.flush) begin
            map_vld_d = '0;
        end else if (accept_s) begin
            for (int j = 0; j < NDEC; j++) begin
                if (bus.rn_valid[j] && bus.rn_makes_rd[j] && (bus.rn_rd[5*j +: 5] != 5'd0) &&
                    (int'(bus.rn_rd[5*j +: 5]) < NARCH)) begin
                    map_vld_d[bus.rn_rd[5*j +: 5]] = 1'b1;
                    map_tag_d[bus.rn_rd[5*j +: 5]] = rn_st_s[j];
                end else begin
                    map_vld_d = map_vld_d;
                end
            end
        end else if (state_q == S_REBUILD) begin
            // Ascending station order so the younger producer overwrites the older one.
            for (int i = 0; i < NDEC; i++) begin
                if ((i < int'(rb_cnt_s)) && win_mk_q[rb_st_s[i]] &&
                    (win_rd_q[rb_st_s[i]] != 5'd0) && !bus.commit_done[rb_st_s[i]] &&
                    (int'(win_rd_q[rb_st_s[i]]) < NARCH)) begin
                    map_vld_d[win_rd_q[rb_st_s[i]]] = 1'b1;
                    map_tag_d[win_rd_q[rb_st_s[i]]] = rb_st_s[i];
                end else begin
                    map_vld_d = map_vld_d;
                end
            end
        end else begin
            map_vld_d = map_vld_d;
        end
    end

    // Commit-window record of each accepted slot's destination.
    always_comb begin
        win_rd_d = win_rd_q;
        win_mk_d = win_mk_q;
        if (accept_s) begin
            for (int j = 0; j < NDEC; j++) begin
                if (bus.rn_valid[j]) begin
                    win_rd_d[rn_st_s[j]] = bus.rn_rd[5*j +: 5];
                    win_mk_d[rn_st_s[j]] = bus.rn_makes_rd[j];
                end else begin
                    win_mk_d = win_mk_d;
                end
            end
        end else begin
            win_mk_d = win_mk_d;
        end
    end

    // Control and map state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            end_q     <= '0;
            map_vld_q <= '0;
            map_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            end_q     <= end_d;
            map_vld_q <= map_vld_d;
            map_tag_q <= map_tag_d;
        end
    end

    // Window storage carries no reset; entries are only read once written by an accepted group.
    always_ff @(posedge clk) begin
        win_rd_q <= win_rd_d;
        win_mk_q <= win_mk_d;
    end

endmodule
